// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the DRAM slot arbiter.
package dram_arb_pkg;

  // Owner of the current DRAM cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VIDEO   = 2'd1,
    REFRESH = 2'd2,
    CPU     = 2'd3
  } owner_t;

  // Video bandwidth codes; any other code behaves like BW_1_4.
  localparam logic [1:0] BW_1_8 = 2'b00;
  localparam logic [1:0] BW_1_4 = 2'b01;
  localparam logic [1:0] BW_1_2 = 2'b10;

  // True when the given slot is reserved for video at the given share.
  function automatic logic is_video_slot(input logic [2:0] slot, input logic [1:0] bw);
    case (bw)
      BW_1_8:  return (slot == 3'd7);
      BW_1_2:  return slot[0];
      default: return (slot[1:0] == 2'b11);
    endcase
  endfunction

endpackage

// File: rtl/dram_slot_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the DRAM controller.
interface dram_slot_arbiter_if #(parameter int AW = 21);
  logic          cend;
  logic          video_go;
  logic [1:0]    video_bw;
  logic [AW-1:0] video_addr;
  logic          video_next;
  logic          video_strobe;
  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wrdata;
  logic          cpu_next;
  logic          cpu_strobe;
  logic          dram_req;
  logic          dram_rnw;
  logic          dram_rfsh;
  logic [AW-1:0] dram_addr;
  logic [15:0]   dram_wrdata;
  logic [15:0]   dram_rddata;

  // Arbiter side.
  modport slave (
    input  cend, video_go, video_bw, video_addr, cpu_req, cpu_rnw, cpu_addr,
           cpu_wrdata, dram_rddata,
    output video_next, video_strobe, cpu_next, cpu_strobe, dram_req, dram_rnw,
           dram_rfsh, dram_addr, dram_wrdata
  );

  // Requester / controller side.
  modport master (
    output cend, video_go, video_bw, video_addr, cpu_req, cpu_rnw, cpu_addr,
           cpu_wrdata, dram_rddata,
    input  video_next, video_strobe, cpu_next, cpu_strobe, dram_req, dram_rnw,
           dram_rfsh, dram_addr, dram_wrdata
  );
endinterface

// File: rtl/dram_refresh_timer.sv
// Refresh period counter: raises pend once per PERIOD ticks, cleared by ack.
module dram_refresh_timer #(
  parameter int PERIOD = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic ack,
  output logic pend
);
  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] count_reg;

  // Count DRAM cycles; a wrap sets pend and wins over a same-cycle ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      pend      <= 1'b0;
    end else if (tick) begin
      if (count_reg == CW'(PERIOD - 1)) begin
        count_reg <= '0;
        pend      <= 1'b1;
      end else begin
        count_reg <= count_reg + CW'(1);
        if (ack) pend <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/dram_slot_arbiter.sv
// Time-slot arbiter sharing the DRAM cycle stream between video, refresh and CPU.
module dram_slot_arbiter
  import dram_arb_pkg::*;
#(
  parameter int AW             = 21,
  parameter int REFRESH_PERIOD = 128
) (
  input  logic                clk,
  input  logic                rst,
  dram_slot_arbiter_if.slave  bus
);
  owner_t        owner_reg, owner_next;
  logic [2:0]    slot_reg, slot_next;
  logic          rfsh_pend, rfsh_ack;
  logic          dram_req_reg, dram_rnw_reg, dram_rfsh_reg;
  logic [AW-1:0] dram_addr_reg;
  logic [15:0]   dram_wrdata_reg;

  dram_refresh_timer #(.PERIOD(REFRESH_PERIOD)) u_refresh_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (bus.cend),
    .ack  (rfsh_ack),
    .pend (rfsh_pend)
  );

  // Owner register: reloaded only at cycle boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner_reg <= IDLE;
    else     owner_reg <= owner_next;
  end

  // Arbitrate the upcoming slot and produce the grant/strobe pulses.
  always_comb begin
    slot_next        = slot_reg + 3'd1;
    owner_next       = owner_reg;
    rfsh_ack         = 1'b0;
    bus.video_next   = 1'b0;
    bus.cpu_next     = 1'b0;
    bus.video_strobe = 1'b0;
    bus.cpu_strobe   = 1'b0;
    if (bus.cend) begin
      if (bus.video_go && is_video_slot(slot_next, bus.video_bw)) owner_next = VIDEO;
      else if (rfsh_pend)                                        owner_next = REFRESH;
      else if (bus.cpu_req)                                      owner_next = CPU;
      else                                                       owner_next = IDLE;
      rfsh_ack         = (owner_next == REFRESH);
      // Pulses are suppressed while reset is held so an aborted cycle stays silent.
      bus.video_next   = !rst && (owner_next == VIDEO);
      bus.cpu_next     = !rst && (owner_next == CPU);
      bus.video_strobe = (owner_reg == VIDEO);
      bus.cpu_strobe   = (owner_reg == CPU) && dram_rnw_reg;
    end
  end

  // Slot counter and DRAM-side registers, updated at the granting boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_reg        <= 3'd0;
      dram_req_reg    <= 1'b0;
      dram_rnw_reg    <= 1'b0;
      dram_rfsh_reg   <= 1'b0;
      dram_addr_reg   <= '0;
      dram_wrdata_reg <= '0;
    end else if (bus.cend) begin
      slot_reg <= slot_next;
      case (owner_next)
        VIDEO: begin
          dram_req_reg  <= 1'b1;
          dram_rnw_reg  <= 1'b1;
          dram_rfsh_reg <= 1'b0;
          dram_addr_reg <= bus.video_addr;
        end
        REFRESH: begin
          dram_req_reg  <= 1'b0;
          dram_rnw_reg  <= 1'b1;
          dram_rfsh_reg <= 1'b1;
        end
        CPU: begin
          dram_req_reg    <= 1'b1;
          dram_rnw_reg    <= bus.cpu_rnw;
          dram_rfsh_reg   <= 1'b0;
          dram_addr_reg   <= bus.cpu_addr;
          dram_wrdata_reg <= bus.cpu_wrdata;
        end
        default: begin
          dram_req_reg  <= 1'b0;
          dram_rnw_reg  <= 1'b0;
          dram_rfsh_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dram_req    = dram_req_reg;
  assign bus.dram_rnw    = dram_rnw_reg;
  assign bus.dram_rfsh   = dram_rfsh_reg;
  assign bus.dram_addr   = dram_addr_reg;
  assign bus.dram_wrdata = dram_wrdata_reg;
endmodule

// File: tb/tb_dram_slot_arbiter.sv
// Directed bench for dram_slot_arbiter with a small slot/refresh reference model.
module tb_dram_slot_arbiter;
  import dram_arb_pkg::*;

  localparam int AW = 21;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dram_slot_arbiter_if #(.AW(AW)) bus ();

  dram_slot_arbiter #(.AW(AW), .REFRESH_PERIOD(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  owner_t        m_owner;
  owner_t        last_e;
  int            m_slot, m_rcnt;
  bit            m_pend, m_rnw;
  logic [AW-1:0] m_addr;
  logic [15:0]   m_wdata;
  longint        t_next;
  bit            got_vn, got_cn, got_vs, got_cs;
  int            n_vid, n_cpu, n_rfsh;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit tb_vid(input int s, input logic [1:0] bw);
    case (bw)
      2'b00:   return s == 7;
      2'b10:   return (s % 2) == 1;
      default: return (s % 4) == 3;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = IDLE; last_e = IDLE; m_slot = 0; m_rcnt = 0; m_pend = 0;
    m_rnw = 0; m_addr = '0; m_wdata = '0; t_next = -1;
  endtask

  // One DRAM cycle: cend high for one clk, then three idle clks.
  task automatic step();
    owner_t e;
    int ns;
    ns = (m_slot + 1) % 8;
    if (bus.video_go && tb_vid(ns, bus.video_bw)) e = VIDEO;
    else if (m_pend)                              e = REFRESH;
    else if (bus.cpu_req)                         e = CPU;
    else                                          e = IDLE;
    @(negedge clk);
    bus.cend = 1'b1;
    #1;
    got_vn = bus.video_next; got_cn = bus.cpu_next;
    got_vs = bus.video_strobe; got_cs = bus.cpu_strobe;
    check("video_next",   got_vn, e == VIDEO);
    check("cpu_next",     got_cn, e == CPU);
    check("video_strobe", got_vs, m_owner == VIDEO);
    check("cpu_strobe",   got_cs, (m_owner == CPU) && m_rnw);
    if (got_vs && t_next >= 0) check("grant_to_strobe_ns", 32'($time - t_next), 32'd40);
    if (got_vn) t_next = $time;
    if (got_vn) n_vid++;
    if (got_cn) n_cpu++;
    if (m_rcnt == 127) begin
      m_rcnt = 0; m_pend = 1;
    end else begin
      m_rcnt++;
      if (e == REFRESH) m_pend = 0;
    end
    case (e)
      VIDEO:   begin m_rnw = 1; m_addr = bus.video_addr; end
      REFRESH: m_rnw = 1;
      CPU:     begin m_rnw = bus.cpu_rnw; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wrdata; end
      default: m_rnw = 0;
    endcase
    m_owner = e; last_e = e; m_slot = ns;
    @(negedge clk);
    bus.cend = 1'b0;
    check("dram_req",    bus.dram_req,  (e == VIDEO) || (e == CPU));
    check("dram_rfsh",   bus.dram_rfsh, e == REFRESH);
    check("dram_rnw",    bus.dram_rnw,  m_rnw);
    check("dram_addr",   32'(bus.dram_addr), 32'(m_addr));
    check("dram_wrdata", bus.dram_wrdata, m_wdata);
    if (bus.dram_rfsh) n_rfsh++;
    $display("cycle slot=%0d owner=%s req=%b rnw=%b rfsh=%b addr=%h wdata=%h",
             m_slot, e.name(), bus.dram_req, bus.dram_rnw, bus.dram_rfsh,
             bus.dram_addr, bus.dram_wrdata);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_video_next"},   bus.video_next,   1'b0);
    check({tag, "_video_strobe"}, bus.video_strobe, 1'b0);
    check({tag, "_cpu_next"},     bus.cpu_next,     1'b0);
    check({tag, "_cpu_strobe"},   bus.cpu_strobe,   1'b0);
    check({tag, "_dram_req"},     bus.dram_req,     1'b0);
    check({tag, "_dram_rnw"},     bus.dram_rnw,     1'b0);
    check({tag, "_dram_rfsh"},    bus.dram_rfsh,    1'b0);
    check({tag, "_dram_addr"},    32'(bus.dram_addr), 32'd0);
    check({tag, "_dram_wrdata"},  bus.dram_wrdata,  16'd0);
  endtask

  initial begin
    bit found;
    int first_vid;
    rst = 1'b1;
    bus.cend = 0; bus.video_go = 0; bus.video_bw = BW_1_8; bus.video_addr = '0;
    bus.cpu_req = 0; bus.cpu_rnw = 1; bus.cpu_addr = '0; bus.cpu_wrdata = '0;
    bus.dram_rddata = 16'hBEEF;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // 1/8 share with CPU always requesting: 17 video, 1 refresh, 118 CPU in 136 cycles
    bus.video_go = 1; bus.video_bw = BW_1_8; bus.video_addr = 21'h012345;
    bus.cpu_req = 1; bus.cpu_rnw = 1; bus.cpu_addr = 21'h00F00;
    n_vid = 0; n_cpu = 0; n_rfsh = 0;
    for (int i = 0; i < 136; i++) step();
    check("share_1_8_video_count", n_vid, 17);
    check("share_1_8_refresh_count", n_rfsh, 1);
    check("share_1_8_cpu_count", n_cpu, 118);

    // 1/4 share: grants at slots 3 and 7, address captured at grant
    bus.video_bw = BW_1_4; bus.cpu_req = 0; n_vid = 0;
    for (int i = 0; i < 16; i++) begin
      bus.video_addr = 21'h100000 + 21'(i * 3);
      step();
    end
    check("share_1_4_video_count", n_vid, 4);

    // 1/2 share with a CPU write landing on an even slot
    bus.video_bw = BW_1_2;
    bus.cpu_req = 1; bus.cpu_rnw = 0; bus.cpu_addr = 21'h0ABCD; bus.cpu_wrdata = 16'h1234;
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      found = got_cn;
    end
    bus.cpu_req = 0; bus.cpu_rnw = 1;
    check("wr_granted", found, 1'b1);
    check("wr_dram_rnw", bus.dram_rnw, 1'b0);
    check("wr_dram_wrdata", bus.dram_wrdata, 16'h1234);
    check("wr_dram_addr", 32'(bus.dram_addr), 32'h0ABCD);
    step();
    check("wr_no_cpu_strobe", got_cs, 1'b0);

    // Refresh beats a waiting CPU, CPU follows on the next slot
    bus.video_go = 0; bus.video_bw = BW_1_8;
    bus.cpu_req = 1; bus.cpu_addr = 21'h00777;
    found = 0;
    for (int i = 0; i < 140 && !found; i++) begin
      step();
      found = m_pend;
    end
    check("rfsh_pending_reached", found, 1'b1);
    step();
    check("rfsh_wins_rfsh", bus.dram_rfsh, 1'b1);
    check("rfsh_wins_no_cpu_next", got_cn, 1'b0);
    step();
    check("cpu_after_rfsh_next", got_cn, 1'b1);
    check("rfsh_cleared", bus.dram_rfsh, 1'b0);

    // Unused video slot goes to CPU; with no requesters the cycle idles
    for (int i = 0; i < 8 && m_slot != 6; i++) step();
    step();
    check("unused_slot_7_cpu", got_cn, 1'b1);
    check("unused_slot_7_no_video", got_vn, 1'b0);
    bus.cpu_req = 0;
    step();
    check("idle_dram_req", bus.dram_req, 1'b0);
    check("idle_no_next", got_cn | got_vn, 1'b0);

    // Reset shortly after a video grant aborts the cycle
    bus.video_go = 1; bus.video_bw = BW_1_8; bus.video_addr = 21'h1F0F0;
    found = 0;
    for (int i = 0; i < 9 && !found; i++) begin
      step();
      found = got_vn;
    end
    check("pre_reset_video_grant", found, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    bus.cend = 1'b1;
    #1;
    check("midrst_no_video_strobe", bus.video_strobe, 1'b0);
    check("midrst_no_video_next", bus.video_next, 1'b0);
    @(negedge clk);
    bus.cend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    first_vid = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (got_vn && first_vid < 0) first_vid = i;
    end
    check("post_reset_first_video_cycle", first_vid, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
